// File: rtl/wb_arb_pkg.sv
// Shared write-back definitions: grant encodings, register-file geometry and
// the register-0 address.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    WB_GNT_NONE = 2'd0,
    WB_GNT_EX   = 2'd1,
    WB_GNT_LQ   = 2'd2
  } wb_gnt_e;

  function automatic logic rd_writes(input logic [REG_ADDR_W-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_ldq.sv
// In-order circular load-return queue with per-entry kill bits and an
// rd compare-and-kill port used for WAW ordering against execute writes.
module wb_ldq
  import wb_arb_pkg::*;
#(
  parameter int LDQ_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [REG_ADDR_W-1:0]          push_rd_i,
  input  logic [REG_DATA_W-1:0]          push_data_i,
  input  logic                           push_kill_i,
  input  logic                           pop_i,
  input  logic                           kill_i,
  input  logic [REG_ADDR_W-1:0]          kill_rd_i,
  output logic [REG_ADDR_W-1:0]          head_rd_o,
  output logic [REG_DATA_W-1:0]          head_data_o,
  output logic                           head_kill_o,
  output logic [$clog2(LDQ_DEPTH+1)-1:0] cnt_o
);

  localparam int PTR_W = $clog2(LDQ_DEPTH);
  localparam int CNT_W = $clog2(LDQ_DEPTH + 1);

  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LDQ_DEPTH-1:0] vld_q, vld_d;
  logic [LDQ_DEPTH-1:0] kill_q, kill_d;

  logic [REG_ADDR_W-1:0] rd_mem   [LDQ_DEPTH];
  logic [REG_DATA_W-1:0] data_mem [LDQ_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LDQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    kill_d   = kill_q;
    if (kill_i) begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        if (vld_q[i] && (rd_mem[i] == kill_rd_i)) kill_d[i] = 1'b1;
      end
    end
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    // Push last: when full, push and pop share the same slot and the new entry must win.
    if (push_i) begin
      vld_d[wr_ptr_q]  = 1'b1;
      kill_d[wr_ptr_q] = push_kill_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      kill_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      kill_q   <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_mem[wr_ptr_q]   <= push_rd_i;
      data_mem[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_rd_o   = rd_mem[rd_ptr_q];
  assign head_data_o = data_mem[rd_ptr_q];
  assign head_kill_o = kill_q[rd_ptr_q];
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/wb_arb.sv
// Write-back arbiter sharing the register-file write port between execute and
// queued load returns. Optional load bypass enabled by WB_ARB_LD_BYPASS_EN.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int LDQ_DEPTH = 2,
  parameter int AGE_MAX   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ex_valid_i,
  input  logic [REG_ADDR_W-1:0]          ex_rd_i,
  input  logic [REG_DATA_W-1:0]          ex_data_i,
  output logic                           ex_stall_o,
  input  logic                           ld_valid_i,
  input  logic [REG_ADDR_W-1:0]          ld_rd_i,
  input  logic [REG_DATA_W-1:0]          ld_data_i,
  output logic                           ld_ready_o,
  output logic                           rf_we_o,
  output logic [REG_ADDR_W-1:0]          rf_waddr_o,
  output logic [REG_DATA_W-1:0]          rf_wdata_o,
  output logic [$clog2(LDQ_DEPTH+1)-1:0] ldq_cnt_o
);

  localparam int CNT_W = $clog2(LDQ_DEPTH + 1);
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  wb_gnt_e               gnt;
  logic                  ldq_empty, ldq_full;
  logic                  bypass, push, pop, kill, push_kill;
  logic [CNT_W-1:0]      cnt;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [REG_DATA_W-1:0] head_data;
  logic                  head_kill;

  logic [AGE_W-1:0]      age_q, age_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [REG_DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  assign ldq_empty = (cnt == '0);
  assign ldq_full  = (cnt == CNT_W'(LDQ_DEPTH));

  always_comb begin
    gnt = WB_GNT_NONE;
    if (!ldq_empty && (!ex_valid_i || ldq_full || (age_q >= AGE_W'(AGE_MAX)))) gnt = WB_GNT_LQ;
    else if (ex_valid_i) gnt = WB_GNT_EX;
  end

  assign ex_stall_o = ex_valid_i & (gnt != WB_GNT_EX);
  assign ld_ready_o = !ldq_full | (gnt == WB_GNT_LQ);

  always_comb begin
`ifdef WB_ARB_LD_BYPASS_EN
    bypass = ld_valid_i & ldq_empty & ~ex_valid_i;
`else
    bypass = 1'b0;
`endif
    push      = ld_valid_i & ld_ready_o & ~bypass;
    pop       = (gnt == WB_GNT_LQ);
    // Queued loads are older than the execute result, so a matching rd must not land after it.
    kill      = (gnt == WB_GNT_EX) & rd_writes(ex_rd_i);
    push_kill = kill & (ld_rd_i == ex_rd_i);
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if ((gnt == WB_GNT_EX) && rd_writes(ex_rd_i)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ex_rd_i;
      rf_wdata_d = ex_data_i;
    end else if ((gnt == WB_GNT_LQ) && !head_kill && rd_writes(head_rd)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end else if (bypass && rd_writes(ld_rd_i)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ld_rd_i;
      rf_wdata_d = ld_data_i;
    end
    age_d = age_q;
    if (ldq_empty || pop) age_d = '0;
    else if (age_q < AGE_W'(AGE_MAX)) age_d = age_q + AGE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      age_q      <= age_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  wb_ldq #(
    .LDQ_DEPTH(LDQ_DEPTH)
  ) u_ldq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_rd_i  (ld_rd_i),
    .push_data_i(ld_data_i),
    .push_kill_i(push_kill),
    .pop_i      (pop),
    .kill_i     (kill),
    .kill_rd_i  (ex_rd_i),
    .head_rd_o  (head_rd),
    .head_data_o(head_data),
    .head_kill_o(head_kill),
    .cnt_o      (cnt)
  );

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign ldq_cnt_o  = cnt;

endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed scenarios then random traffic, checked against a
// queue-based reference model of the arbitration rules.
module tb_wb_arb;

  localparam int DEPTH   = 2;
  localparam int AGE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic [31:0] ex_data_i = '0;
  logic        ex_stall_o;
  logic        ld_valid_i = 1'b0;
  logic [4:0]  ld_rd_i = '0;
  logic [31:0] ld_data_i = '0;
  logic        ld_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [1:0]  ldq_cnt_o;

  always #5 clk = ~clk;

  wb_arb #(.LDQ_DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid_i(ex_valid_i),
    .ex_rd_i   (ex_rd_i),
    .ex_data_i (ex_data_i),
    .ex_stall_o(ex_stall_o),
    .ld_valid_i(ld_valid_i),
    .ld_rd_i   (ld_rd_i),
    .ld_data_i (ld_data_i),
    .ld_ready_o(ld_ready_o),
    .rf_we_o   (rf_we_o),
    .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o),
    .ldq_cnt_o (ldq_cnt_o)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        kill;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  int          age;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_gnt;  // 0 none, 1 execute, 2 load queue
  logic        m_bypass, m_stall, m_ready;

  logic [31:0] rf_sh [32];
  logic        st_obs, rdy_obs;
  logic [31:0] cnt_obs;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    age = 0;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic model_decide();
    int n = q.size();
    m_gnt = 0;
    if (n > 0 && (!ex_valid_i || n == DEPTH || age >= AGE_MAX)) m_gnt = 2;
    else if (ex_valid_i) m_gnt = 1;
`ifdef WB_ARB_LD_BYPASS_EN
    m_bypass = ld_valid_i && n == 0 && !ex_valid_i;
`else
    m_bypass = 1'b0;
`endif
    m_stall = ex_valid_i && m_gnt != 1;
    m_ready = (n < DEPTH) || m_gnt == 2;
  endtask

  task automatic model_commit();
    int   n = q.size();
    ent_t h, e;
    m_we = 1'b0;
    if (m_gnt == 1 && ex_rd_i != 0) begin
      m_we = 1'b1; m_waddr = ex_rd_i; m_wdata = ex_data_i;
      for (int i = 0; i < q.size(); i++)
        if (q[i].rd == ex_rd_i) begin e = q[i]; e.kill = 1'b1; q[i] = e; end
    end
    if (m_gnt == 2) begin
      h = q.pop_front();
      if (!h.kill && h.rd != 0) begin m_we = 1'b1; m_waddr = h.rd; m_wdata = h.data; end
    end
    if (m_bypass) begin
      if (ld_rd_i != 0) begin m_we = 1'b1; m_waddr = ld_rd_i; m_wdata = ld_data_i; end
    end else if (ld_valid_i && m_ready) begin
      e.rd = ld_rd_i; e.data = ld_data_i;
      e.kill = (m_gnt == 1) && ex_rd_i != 0 && ld_rd_i == ex_rd_i;
      q.push_back(e);
    end
    if (n == 0 || m_gnt == 2) age = 0;
    else if (age < AGE_MAX) age++;
  endtask

  task automatic step(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                      input logic ldv, input logic [4:0] ldrd, input logic [31:0] ldd);
    ex_valid_i = exv; ex_rd_i = exrd; ex_data_i = exd;
    ld_valid_i = ldv; ld_rd_i = ldrd; ld_data_i = ldd;
    @(negedge clk);
    model_decide();
    st_obs = ex_stall_o; rdy_obs = ld_ready_o; cnt_obs = 32'(ldq_cnt_o);
    chk("ex_stall", 32'(ex_stall_o), 32'(m_stall));
    chk("ld_ready", 32'(ld_ready_o), 32'(m_ready));
    chk("ldq_cnt", 32'(ldq_cnt_o), 32'(q.size()));
    @(posedge clk);
    model_commit();
    #1;
    chk("rf_we", 32'(rf_we_o), 32'(m_we));
    chk("rf_waddr", 32'(rf_waddr_o), 32'(m_waddr));
    chk("rf_wdata", rf_wdata_o, m_wdata);
    if (rf_we_o === 1'b1) rf_sh[rf_waddr_o] = rf_wdata_o;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exv, ldv;
    logic [4:0]  exrd, ldrd;
    logic [31:0] exd, ldd;
    for (int i = 0; i < 32; i++) rf_sh[i] = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 32'(rf_we_o), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_cnt", 32'(ldq_cnt_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Execute only
    step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
    chk("exonly_stall", 32'(st_obs), 32'd0);
    chk("exonly_we", 32'(rf_we_o), 32'd1);
    chk("exonly_addr", 32'(rf_waddr_o), 32'd3);
    chk("exonly_data", rf_wdata_o, 32'h11);
    idle();

    // Starvation limit: load rd=5 queued, execute held continuously
    step(1'b1, 5'd1, 32'h100, 1'b1, 5'd5, 32'hAA);
    for (int i = 0; i < AGE_MAX; i++) begin
      step(1'b1, 5'd2, 32'h200 + 32'(i), 1'b0, 5'd0, 32'd0);
      chk("starve_ex_win", 32'(st_obs), 32'd0);
      chk("starve_ex_addr", 32'(rf_waddr_o), 32'd2);
    end
    step(1'b1, 5'd2, 32'h204, 1'b0, 5'd0, 32'd0);
    chk("starve_lq_stall", 32'(st_obs), 32'd1);
    chk("starve_lq_addr", 32'(rf_waddr_o), 32'd5);
    chk("starve_lq_data", rf_wdata_o, 32'hAA);
    step(1'b1, 5'd2, 32'h204, 1'b0, 5'd0, 32'd0);
    chk("starve_ex_resume", 32'(st_obs), 32'd0);

    // Queue full: push+pop in the same cycle
    step(1'b1, 5'd4, 32'h40, 1'b1, 5'd6, 32'h60);
    step(1'b1, 5'd8, 32'h80, 1'b1, 5'd10, 32'hA0);
    step(1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0);
    chk("full_cnt", cnt_obs, 32'd2);
    chk("full_ready", 32'(rdy_obs), 32'd1);
    chk("full_stall", 32'(st_obs), 32'd1);
    chk("full_pop_addr", 32'(rf_waddr_o), 32'd6);
    idle();
    idle();
    idle();
    chk("full_drain", 32'(ldq_cnt_o), 32'd0);

    // WAW kill
    step(1'b1, 5'd1, 32'h5, 1'b1, 5'd7, 32'h1);
    step(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
    chk("waw_ex_addr", 32'(rf_waddr_o), 32'd7);
    chk("waw_ex_data", rf_wdata_o, 32'h2);
    idle();
    chk("waw_kill_we", 32'(rf_we_o), 32'd0);
    chk("waw_reg7", rf_sh[7], 32'h2);

    // Register 0 dropped
    step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    chk("r0_we", 32'(rf_we_o), 32'd0);

    // Load latency into an empty queue
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
`ifdef WB_ARB_LD_BYPASS_EN
    chk("lat_we_n1", 32'(rf_we_o), 32'd1);
    chk("lat_addr_n1", 32'(rf_waddr_o), 32'd9);
    idle();
    chk("lat_we_n2", 32'(rf_we_o), 32'd0);
`else
    chk("lat_we_n1", 32'(rf_we_o), 32'd0);
    idle();
    chk("lat_we_n2", 32'(rf_we_o), 32'd1);
    chk("lat_addr_n2", 32'(rf_waddr_o), 32'd9);
`endif

    // Asynchronous reset with two loads queued
    step(1'b1, 5'd1, 32'h31, 1'b1, 5'd13, 32'hD0);
    step(1'b1, 5'd2, 32'h32, 1'b1, 5'd14, 32'hE0);
    chk("prerst_cnt", 32'(ldq_cnt_o), 32'd2);
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(rf_we_o), 32'd0);
    chk("arst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("arst_wdata", rf_wdata_o, 32'd0);
    chk("arst_cnt", 32'(ldq_cnt_o), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_cnt", 32'(ldq_cnt_o), 32'd0);
    chk("postrst_we", 32'(rf_we_o), 32'd0);

    // Random traffic honouring the hold-until-accepted protocol
    exv = 1'b0; ldv = 1'b0; exrd = '0; ldrd = '0; exd = '0; ldd = '0;
    st_obs = 1'b0; rdy_obs = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!(exv && st_obs)) begin
        exv = 1'($urandom_range(0, 1));
        exrd = 5'($urandom_range(0, 7));
        exd = $urandom;
      end
      if (!(ldv && !rdy_obs)) begin
        ldv = 1'($urandom_range(0, 1));
        ldrd = 5'($urandom_range(0, 7));
        ldd = $urandom;
      end
      step(exv, exrd, exd, ldv, ldrd, ldd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
